// File: rtl/minv_io_ctrl.sv
// Host-side sequencer for the MINV_modify core: streams a/p in, fires, waits for ready, unloads x1/x2.
// Optional WAIT-state watchdog enabled by defining MINV_TIMEOUT_EN.
module minv_io_ctrl #(
    parameter int DW        = 16,
    parameter int NW        = 16,
    parameter int TO_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW*NW-1:0] a_in,
    input  logic [DW*NW-1:0] p_in,
    output logic             busy,
    output logic [DW-1:0]    datain,
    output logic             loada,
    output logic             loadp,
    output logic             minv_en,
    input  logic             minv_rdy,
    input  logic             minv_flag,
    input  logic [DW-1:0]    regx1out,
    input  logic [DW-1:0]    regx2out,
    output logic             outx1,
    output logic             outx2,
    output logic [DW*NW-1:0] x1_res,
    output logic [DW*NW-1:0] x2_res,
    output logic             flag_res,
    output logic             done,
    output logic             timeout
);

    localparam int W  = DW * NW;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADA, S_LOADP, S_FIRE, S_WAIT, S_UNLD, S_DRAIN, S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic [NW-1:0][DW-1:0]  a_reg;
    logic [NW-1:0][DW-1:0]  p_reg;

    assign cnt_nx = cnt + 1'b1;

`ifdef MINV_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] wcnt;
`else
    assign timeout = 1'b0;
`endif

    // Outputs are registered alongside the state, so they always describe the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            p_reg    <= '0;
            busy     <= 1'b0;
            datain   <= '0;
            loada    <= 1'b0;
            loadp    <= 1'b0;
            minv_en  <= 1'b0;
            outx1    <= 1'b0;
            outx2    <= 1'b0;
            x1_res   <= '0;
            x2_res   <= '0;
            flag_res <= 1'b0;
            done     <= 1'b0;
`ifdef MINV_TIMEOUT_EN
            wcnt     <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            minv_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOADA;
                        busy     <= 1'b1;
                        a_reg    <= a_in;
                        p_reg    <= p_in;
                        cnt      <= '0;
                        loada    <= 1'b1;
                        datain   <= a_in[DW-1:0];
                        x1_res   <= '0;
                        x2_res   <= '0;
                        flag_res <= 1'b0;
                    end
                end
                S_LOADA: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        loada  <= 1'b0;
                        loadp  <= 1'b1;
                        datain <= p_reg[0];
                        state  <= S_LOADP;
                    end else begin
                        cnt    <= cnt_nx;
                        datain <= a_reg[cnt_nx];
                    end
                end
                S_LOADP: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        loadp   <= 1'b0;
                        minv_en <= 1'b1;
                        datain  <= '0;
                        state   <= S_FIRE;
                    end else begin
                        cnt    <= cnt_nx;
                        datain <= p_reg[cnt_nx];
                    end
                end
                S_FIRE: begin
`ifdef MINV_TIMEOUT_EN
                    wcnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
`ifdef MINV_TIMEOUT_EN
                    // The pulse cycle is the last WAIT cycle; it wins over a coincident ready.
                    if (timeout) begin
                        timeout <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (minv_rdy) begin
                        flag_res <= minv_flag;
                        cnt      <= '0;
                        outx1    <= 1'b1;
                        outx2    <= 1'b1;
                        state    <= S_UNLD;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == TW'(TO_CYCLES - 2))
                            timeout <= 1'b1;
                    end
`else
                    if (minv_rdy) begin
                        flag_res <= minv_flag;
                        cnt      <= '0;
                        outx1    <= 1'b1;
                        outx2    <= 1'b1;
                        state    <= S_UNLD;
                    end
`endif
                end
                S_UNLD: begin
                    // Read data trails the enable by one cycle, so cycle 0 has nothing to capture.
                    if (cnt != '0) begin
                        x1_res <= {regx1out, x1_res[W-1:DW]};
                        x2_res <= {regx2out, x2_res[W-1:DW]};
                    end
                    if (cnt == LAST) begin
                        outx1 <= 1'b0;
                        outx2 <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                S_DRAIN: begin
                    x1_res <= {regx1out, x1_res[W-1:DW]};
                    x2_res <= {regx2out, x2_res[W-1:DW]};
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minv_io_ctrl.sv
// Bench for minv_io_ctrl: drives host transactions and plays the core, checking load stream,
// strobes, latency and reassembled results against values computed from the operands.
module tb_minv_io_ctrl;

    localparam int DW = 16;
    localparam int NW = 16;
    localparam int W  = DW * NW;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in, p_in;
    logic          busy, loada, loadp, minv_en, outx1, outx2, flag_res, done, timeout;
    logic [DW-1:0] datain;
    logic          minv_rdy, minv_flag;
    logic [DW-1:0] regx1out, regx2out;
    logic [W-1:0]  x1_res, x2_res;

    int checks = 0;
    int errors = 0;

    minv_io_ctrl #(.DW(DW), .NW(NW), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .p_in(p_in),
        .busy(busy), .datain(datain), .loada(loada), .loadp(loadp),
        .minv_en(minv_en), .minv_rdy(minv_rdy), .minv_flag(minv_flag),
        .regx1out(regx1out), .regx2out(regx2out), .outx1(outx1), .outx2(outx2),
        .x1_res(x1_res), .x2_res(x2_res), .flag_res(flag_res), .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; p_in = '0;
        minv_rdy = 1'b0; minv_flag = 1'b0; regx1out = '0; regx2out = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, loada, loadp, minv_en, outx1, outx2, flag_res, done, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0",
                     {busy, loada, loadp, minv_en, outx1, outx2, flag_res, done, timeout});
        end
        checks++;
        if (datain !== '0 || x1_res !== '0 || x2_res !== '0) begin
            errors++;
            $display("FAIL reset_data got datain %h x1 %h x2 %h exp 0", datain, x1_res, x2_res);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    // One full host transaction; this task also plays the core (ready timing and read data).
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] p,
                           input logic [W-1:0] x1, input logic [W-1:0] x2, input logic flg,
                           input int d, input int len, input bit hold, input string name);
        logic [DW-1:0] a_seen[$];
        logic [DW-1:0] p_seen[$];
        int en_cnt = 0, ox1_cnt = 0, ox2_cnt = 0, done_cnt = 0, overlap = 0, to_cnt = 0;
        int cyc = 0, done_cyc = 0, since_en = 0, rd_idx = 0;
        bit en_seen = 0, prev_rd = 0;
        int exp_lat;
        exp_lat = 2 * NW + 1 + d + NW + 2;
        @(negedge clk);
        a_in = a; p_in = p; start = 1'b1; minv_rdy = 1'b0; minv_flag = flg;
        while (cyc < 400 && !(done_cnt != 0 && cyc > done_cyc)) begin
            @(negedge clk);
            cyc++;
            if (prev_rd && rd_idx < NW) begin
                regx1out = x1[DW*rd_idx +: DW];
                regx2out = x2[DW*rd_idx +: DW];
                rd_idx++;
            end
            prev_rd = outx1;
            if (loada) a_seen.push_back(datain);
            if (loadp) p_seen.push_back(datain);
            if (loada && loadp) overlap++;
            if (outx1) ox1_cnt++;
            if (outx2) ox2_cnt++;
            if (timeout) to_cnt++;
            if (minv_en) begin
                en_cnt++;
                en_seen = 1;
                since_en = 0;
            end else if (en_seen) begin
                since_en++;
            end
            if (done_cnt == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_cyc%0d got %b exp 1", name, cyc, busy);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                if (cyc !== exp_lat) begin
                    errors++;
                    $display("FAIL %s latency got %0d exp %0d", name, cyc, exp_lat);
                end
                checks++;
                if (x1_res !== x1) begin
                    errors++;
                    $display("FAIL %s x1_res got %h exp %h", name, x1_res, x1);
                end
                checks++;
                if (x2_res !== x2) begin
                    errors++;
                    $display("FAIL %s x2_res got %h exp %h", name, x2_res, x2);
                end
                checks++;
                if (flag_res !== flg) begin
                    errors++;
                    $display("FAIL %s flag_res got %b exp %b", name, flag_res, flg);
                end
            end else if (done_cnt != 0 && cyc == done_cyc + 1) begin
                checks++;
                if (busy !== 1'b0 || x1_res !== x1 || flag_res !== flg) begin
                    errors++;
                    $display("FAIL %s after_done got busy %b x1 %h flag %b exp 0 %h %b",
                             name, busy, x1_res, flag_res, x1, flg);
                end
            end
            // While start is held, scramble the inputs to prove the latched operands are used.
            start = hold && !(en_seen && since_en >= d);
            if (start) begin
                a_in = rand_wide();
                p_in = rand_wide();
            end
            minv_rdy = en_seen && since_en >= d && since_en < d + len;
        end
        start = 1'b0; minv_rdy = 1'b0;
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", name, done_cnt); end
        checks++;
        if (en_cnt !== 1) begin errors++; $display("FAIL %s minv_en_count got %0d exp 1", name, en_cnt); end
        checks++;
        if (ox1_cnt !== NW || ox2_cnt !== NW) begin
            errors++;
            $display("FAIL %s outx_cycles got %0d/%0d exp %0d", name, ox1_cnt, ox2_cnt, NW);
        end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL %s load_overlap got %0d exp 0", name, overlap); end
        checks++;
        if (to_cnt !== 0) begin errors++; $display("FAIL %s timeout_count got %0d exp 0", name, to_cnt); end
        checks++;
        if (a_seen.size() !== NW || p_seen.size() !== NW) begin
            errors++;
            $display("FAIL %s load_len got %0d/%0d exp %0d", name, a_seen.size(), p_seen.size(), NW);
        end else begin
            for (int i = 0; i < NW; i++) begin
                checks++;
                if (a_seen[i] !== a[DW*i +: DW]) begin
                    errors++;
                    $display("FAIL %s a_word%0d got %h exp %h", name, i, a_seen[i], a[DW*i +: DW]);
                end
                checks++;
                if (p_seen[i] !== p[DW*i +: DW]) begin
                    errors++;
                    $display("FAIL %s p_word%0d got %h exp %h", name, i, p_seen[i], p[DW*i +: DW]);
                end
            end
        end
    endtask

    task automatic test_small();
        run_txn(256'd5, 256'd11, 256'd9, 256'd3, 1'b1, 4, 1, 1'b0, "small");
    endtask

    task automatic test_full_vectors();
        logic [W-1:0] a, p;
        a = 256'h787968b4_1c2d3e4f_5a6b7c8d_9eafb0c1_d2e3f405_16273849_5a6b7c8d_3937e498;
        p = 256'h8542d69e_0a1b2c3d_4e5f6071_8293a4b5_c6d7e8f9_0badcafe_13579bdf_08f1dfc3;
        run_txn(a, p, rand_wide(), rand_wide(), 1'b0, 7, 2, 1'b0, "full");
    endtask

    task automatic test_start_held();
        run_txn(rand_wide(), rand_wide(), rand_wide(), rand_wide(), 1'b1, 12, 1, 1'b1, "held");
    endtask

    task automatic test_reset_midload();
        logic [W-1:0] a;
        a = rand_wide();
        @(negedge clk);
        a_in = a; p_in = rand_wide(); start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (loada !== 1'b1 || datain !== a[DW*7 +: DW]) begin
            errors++;
            $display("FAIL midload_word7 got loada %b datain %h exp 1 %h", loada, datain, a[DW*7 +: DW]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, loada, loadp, minv_en, outx1, outx2, done, timeout} !== 8'b0 || datain !== '0) begin
            errors++;
            $display("FAIL midload_rst got %b datain %h exp 0",
                     {busy, loada, loadp, minv_en, outx1, outx2, done, timeout}, datain);
        end
        @(negedge clk);
        rst = 1'b0;
        run_txn(rand_wide(), rand_wide(), rand_wide(), rand_wide(), 1'b0, 2, 1, 1'b0, "reload");
    endtask

    task automatic test_rdy_level();
        run_txn(rand_wide(), rand_wide(), rand_wide(), rand_wide(), 1'b1, 3, 5, 1'b0, "rdy_level");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++)
            run_txn(rand_wide(), rand_wide(), rand_wide(), rand_wide(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 20)), int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), "random");
    endtask

`ifdef MINV_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0, en_cyc = -1, to_cyc = -1, done_cnt = 0;
        @(negedge clk);
        a_in = rand_wide(); p_in = rand_wide(); start = 1'b1; minv_rdy = 1'b0;
        while (cyc < 300 && !(to_cyc >= 0 && cyc > to_cyc)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (minv_en) en_cyc = cyc;
            if (done) done_cnt++;
            if (timeout && to_cyc < 0) to_cyc = cyc;
            else if (to_cyc >= 0 && cyc == to_cyc + 1) begin
                checks++;
                if (busy !== 1'b0 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL to_after got busy %b timeout %b exp 0 0", busy, timeout);
                end
            end
        end
        checks++;
        if (to_cyc !== en_cyc + TO) begin
            errors++;
            $display("FAIL to_cycle got %0d exp %0d", to_cyc, en_cyc + TO);
        end
        checks++;
        if (done_cnt !== 0 || x1_res !== '0 || x2_res !== '0) begin
            errors++;
            $display("FAIL to_results got done %0d x1 %h x2 %h exp 0", done_cnt, x1_res, x2_res);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_small();
        test_full_vectors();
        test_start_held();
        test_reset_midload();
        test_rdy_level();
        test_back_to_back();
`ifdef MINV_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minv_io_ctrl.md
Name: minv_io_ctrl

Overview:
- Host-side sequencer for the MINV_modify modular-inverse core.
- Latches a 256-bit operand `a` and modulus `p`, then streams each into the core's 16-bit `datain` bus under `loada`/`loadp`.
- Fires `minv_en`, waits for `minv_rdy`, then unloads both result registers via `outx1`/`outx2` and reassembles them into 256-bit words for the host.
- Replaces the hand-driven testbench sequencing; sits directly upstream (load side) and downstream (unload side) of the core.

Parameters:
- DW, 16: core data bus width in bits.
- NW, 16: words per operand; operand width = DW*NW = 256.
- TO_CYCLES, 65536: watchdog limit in WAIT state, in clk cycles (used only with MINV_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  host request; sampled only in IDLE.
- a_in  in  DW*NW  operand a; latched on accepted start.
- p_in  in  DW*NW  modulus p; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- datain  out  DW  word to core.
- loada  out  1  core load-a strobe.
- loadp  out  1  core load-p strobe.
- minv_en  out  1  core start pulse.
- minv_rdy  in  1  core result ready.
- minv_flag  in  1  core status flag.
- regx1out  in  DW  core x1 read word.
- regx2out  in  DW  core x2 read word.
- outx1  out  1  core x1 read enable.
- outx2  out  1  core x2 read enable.
- x1_res  out  DW*NW  assembled x1 result.
- x2_res  out  DW*NW  assembled x2 result.
- flag_res  out  1  minv_flag captured at ready.
- done  out  1  one-cycle result-valid pulse.
- timeout  out  1  watchdog abort pulse; constant 0 without the macro.

Behaviour:
- Reset: every output 0 (datain, x1_res, x2_res all zero); state IDLE; word counter 0; operand latches cleared.
- IDLE:
  - start=1 latches a_in/p_in, clears the counter, and moves to LOADA.
  - start is ignored in all other states.
- LOADA (NW cycles):
  - loada=1; datain = a word[cnt], least-significant word first (word0 = a[DW-1:0]).
  - cnt increments each cycle; on cnt=NW-1, clear cnt and go to LOADP.
  - loada and loadp are never high together.
- LOADP (NW cycles): same pattern with p and loadp=1. Then go to FIRE.
- FIRE (1 cycle): minv_en=1, datain=0. Then go to WAIT.
- WAIT:
  - All core strobes low.
  - On the first cycle minv_rdy=1: capture minv_flag into flag_res, clear cnt, go to UNLD.
  - minv_rdy may be a pulse or a level; only the first high sample is used.
- UNLD (NW cycles): outx1=outx2=1. Core read latency is fixed at 1 cycle:
  - regx1out/regx2out sampled in the cycle after each read cycle.
  - Sample k is shifted into bits [DW*k+DW-1 : DW*k] of x1_res/x2_res, LS word first.
  - After NW cycles go to DRAIN.
- DRAIN (1 cycle): outx1/outx2 low; capture the final word. Then go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
  - x1_res, x2_res and flag_res hold until the next accepted start clears them.
- Total latency, start accept to done: 2*NW + 1 + wait + NW + 2 cycles.
- Asynchronous rst at any point, including mid-load or mid-unload, returns immediately to reset values. A partial load is discarded; the host must re-issue start.
- minv_rdy outside WAIT is ignored.

Optional Feature:
- Macro: MINV_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If minv_rdy is not seen within TO_CYCLES cycles: timeout=1 for one cycle, return to IDLE, no done pulse, results left at 0.
- Undefined: no counter; WAIT is unbounded; timeout tied to 0.

Test Plan:
1. Small operands: a=5, p=11; core model returns x1=9 (5*9 mod 11 = 1), flag=1.
   - Expect datain=5 then 0x0 x15 with loada; 11 then 0x0 x15 with loadp.
   - Expect one minv_en pulse, then x1_res=9, flag_res=1, done one cycle after DRAIN.
2. Full 256-bit vectors: a=0x787968b4…3937e498, p=0x8542d69e…08f1dfc3.
   - Expect first loada word 0xe498 and last 0x7879; first loadp word 0xdfc3 and last 0x8542.
   - Expect x1_res/x2_res to equal the model's 256-bit outputs bit-exact.
3. start held high during LOADP and WAIT -> no restart; latched operands unchanged; exactly one done per accepted start.
4. rst asserted on the 8th LOADA cycle -> all outputs 0 immediately, busy=0. A new start reloads from word0.
5. minv_rdy held high for 5 cycles -> outx1/outx2 high exactly NW=16 cycles, one done.
6. MINV_TIMEOUT_EN defined, TO_CYCLES=100, core never ready -> timeout pulse on cycle 100 of WAIT, busy=0 next cycle, done never asserted.
